lowp_mc: RTL and testbench

Multichannel, cascaded, shift-only exponential low-pass filter: the parametrised successor of the single-channel lowp block. Up to CH interleaved channels share one ORDER-stage pipeline. Each channel has its own programmable time-constant shift and its own seed-on-next-sample control, and samples carry a valid strobe. It sits between the demodulator/decimator output and the measurement readout. No multipliers are used.

---
 rtl/lowp_mc.sv | 148 ++++++++++++++
 tb/tb_lowp_mc.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lowp_mc.sv
// lowp_mc: multichannel cascaded shift-only exponential low-pass filter.
// CH interleaved channels share one ORDER-stage read-modify-write pipeline.
module lowp_mc #(
  parameter int W     = 28,
  parameter int F     = 24,
  parameter int CH    = 4,
  parameter int ORDER = 2,
  parameter int SW    = 5,
  localparam int A    = W + F,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic                 clock_in,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_chan,
  input  logic signed [W-1:0]  in_data,
  input  logic                 cfg_we,
  input  logic                 cfg_seed,
  input  logic [CW-1:0]        cfg_chan,
  input  logic [SW-1:0]        cfg_shift,
  output logic                 out_valid,
  output logic [CW-1:0]        out_chan,
  output logic signed [W-1:0]  out_data
);

  logic          accept;
  logic [SW-1:0] shift_clamp;

  logic [SW-1:0] shift_reg [CH];
  logic          seed_reg  [CH];

  // Per-stage sample context; index s is the input of stage s.
  logic                valid_pipe_reg [ORDER];
  logic [CW-1:0]       chan_pipe_reg  [ORDER];
  logic [SW-1:0]       shift_pipe_reg [ORDER];
  logic                seed_pipe_reg  [ORDER];
  logic signed [A-1:0] data_pipe_reg  [ORDER];

  logic                out_valid_reg;
  logic [CW-1:0]       out_chan_reg;
  logic signed [W-1:0] out_data_reg;

  assign accept      = in_valid && (32'(in_chan) < CH);
  assign shift_clamp = (32'(cfg_shift) > F) ? SW'(F) : cfg_shift;

  // An arm request beats the clear caused by a sample entering on the same channel.
  for (genvar gi = 0; gi < CH; gi++) begin : g_chan
    always_ff @(posedge clock_in) begin
      if (reset) begin
        shift_reg[gi] <= '0;
        seed_reg[gi]  <= 1'b1;
      end else begin
        if (cfg_we && cfg_chan == CW'(gi)) begin
          shift_reg[gi] <= shift_clamp;
        end
        if (cfg_seed && cfg_chan == CW'(gi)) begin
          seed_reg[gi] <= 1'b1;
        end else if (accept && in_chan == CW'(gi)) begin
          seed_reg[gi] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      valid_pipe_reg[0] <= 1'b0;
      chan_pipe_reg[0]  <= '0;
      shift_pipe_reg[0] <= '0;
      seed_pipe_reg[0]  <= 1'b0;
      data_pipe_reg[0]  <= '0;
    end else begin
      valid_pipe_reg[0] <= accept;
      if (accept) begin
        chan_pipe_reg[0]  <= in_chan;
        shift_pipe_reg[0] <= shift_reg[in_chan];
        seed_pipe_reg[0]  <= seed_reg[in_chan];
        data_pipe_reg[0]  <= {in_data, {F{1'b0}}};
      end
    end
  end

  for (genvar gi = 0; gi < ORDER; gi++) begin : g_stage
    logic signed [A-1:0] acc_reg [CH];
    logic signed [A-1:0] cur_w;
    logic signed [A-1:0] new_w;
    logic signed [A:0]   diff_w;
    logic signed [A:0]   step_w;

    // The step lies between acc and u, so the A-bit truncation of the sum is exact.
    always_comb begin
      cur_w  = acc_reg[chan_pipe_reg[gi]];
      diff_w = $signed({data_pipe_reg[gi][A-1], data_pipe_reg[gi]}) - $signed({cur_w[A-1], cur_w});
      step_w = diff_w >>> shift_pipe_reg[gi];
      new_w  = seed_pipe_reg[gi] ? data_pipe_reg[gi]
                                 : A'($signed({cur_w[A-1], cur_w}) + step_w);
    end

    always_ff @(posedge clock_in) begin
      if (reset) begin
        for (int c = 0; c < CH; c++) begin
          acc_reg[c] <= '0;
        end
      end else if (valid_pipe_reg[gi]) begin
        acc_reg[chan_pipe_reg[gi]] <= new_w;
      end
    end

    if (gi < ORDER - 1) begin : g_fwd
      always_ff @(posedge clock_in) begin
        if (reset) begin
          valid_pipe_reg[gi+1] <= 1'b0;
          chan_pipe_reg[gi+1]  <= '0;
          shift_pipe_reg[gi+1] <= '0;
          seed_pipe_reg[gi+1]  <= 1'b0;
          data_pipe_reg[gi+1]  <= '0;
        end else begin
          valid_pipe_reg[gi+1] <= valid_pipe_reg[gi];
          if (valid_pipe_reg[gi]) begin
            chan_pipe_reg[gi+1]  <= chan_pipe_reg[gi];
            shift_pipe_reg[gi+1] <= shift_pipe_reg[gi];
            seed_pipe_reg[gi+1]  <= seed_pipe_reg[gi];
            data_pipe_reg[gi+1]  <= new_w;
          end
        end
      end
    end else begin : g_out
      always_ff @(posedge clock_in) begin
        if (reset) begin
          out_valid_reg <= 1'b0;
          out_chan_reg  <= '0;
          out_data_reg  <= '0;
        end else begin
          out_valid_reg <= valid_pipe_reg[gi];
          if (valid_pipe_reg[gi]) begin
            out_chan_reg <= chan_pipe_reg[gi];
            out_data_reg <= new_w[A-1:F];
          end
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_chan  = out_chan_reg;
  assign out_data  = out_data_reg;

endmodule

// File: tb/tb_lowp_mc.sv
// Bench for lowp_mc: table-driven vectors with a scoreboard queue, plus
// hand-written sequences for shift clamping and mid-stream reset.
module tb_lowp_mc;
  localparam int W     = 28;
  localparam int F     = 24;
  localparam int CH    = 4;
  localparam int ORDER = 2;
  localparam int SW    = 5;
  localparam int CW    = 2;

  logic                clock_in = 1'b0;
  logic                reset    = 1'b1;
  logic                in_valid = 1'b0;
  logic [CW-1:0]       in_chan  = '0;
  logic signed [W-1:0] in_data  = '0;
  logic                cfg_we   = 1'b0;
  logic                cfg_seed = 1'b0;
  logic [CW-1:0]       cfg_chan = '0;
  logic [SW-1:0]       cfg_shift = '0;
  logic                out_valid;
  logic [CW-1:0]       out_chan;
  logic signed [W-1:0] out_data;

  lowp_mc #(.W(W), .F(F), .CH(CH), .ORDER(ORDER), .SW(SW)) dut (
    .clock_in (clock_in),
    .reset    (reset),
    .in_valid (in_valid),
    .in_chan  (in_chan),
    .in_data  (in_data),
    .cfg_we   (cfg_we),
    .cfg_seed (cfg_seed),
    .cfg_chan (cfg_chan),
    .cfg_shift(cfg_shift),
    .out_valid(out_valid),
    .out_chan (out_chan),
    .out_data (out_data)
  );

  always #5 clock_in = ~clock_in;

  int cyc = 0;
  always @(posedge clock_in) cyc <= cyc + 1;

  typedef struct {
    string         tag;
    logic          we;
    logic          sd;
    logic [CW-1:0] cch;
    logic [SW-1:0] csh;
    logic          iv;
    logic [CW-1:0] ich;
    int            din;
    int            dexp;
  } vec_t;

  typedef struct {
    string         tag;
    logic [CW-1:0] ch;
    int            data;
    int            due;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string tag, bit we, bit sd, int cch, int csh,
                              bit iv, int ich, int din, int dexp);
    vec_t v;
    v.tag  = tag;
    v.we   = we;
    v.sd   = sd;
    v.cch  = CW'(cch);
    v.csh  = SW'(csh);
    v.iv   = iv;
    v.ich  = CW'(ich);
    v.din  = din;
    v.dexp = dexp;
    return v;
  endfunction

  // Drive one row for one cycle; a valid sample is due ORDER edges after acceptance.
  task automatic apply(input vec_t v);
    exp_t e;
    @(posedge clock_in); #1;
    cfg_we    = v.we;
    cfg_seed  = v.sd;
    cfg_chan  = v.cch;
    cfg_shift = v.csh;
    in_valid  = v.iv;
    in_chan   = v.ich;
    in_data   = v.din[W-1:0];
    if (v.iv) begin
      e.tag  = v.tag;
      e.ch   = v.ich;
      e.data = v.dexp;
      e.due  = cyc + 1 + ORDER;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    apply(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic drain();
    exp_t e;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clock_in);
    while (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: no output seen, required chan=%0d data=%0d", e.tag, e.ch, e.data);
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  always @(negedge clock_in) begin : mon
    exp_t e;
    if (out_valid !== 1'b0) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL stray: out_valid=%b chan=%0d data=%0d at cycle %0d with none expected",
                 out_valid, out_chan, $signed(out_data), cyc);
      end else begin
        e = sb_q.pop_front();
        if (out_chan !== e.ch || out_data !== W'(e.data) || cyc != e.due) begin
          n_bad++;
          $display("FAIL %s: got chan=%0d data=%0d cycle=%0d, required chan=%0d data=%0d cycle=%0d",
                   e.tag, out_chan, $signed(out_data), cyc, e.ch, e.data, e.due);
        end else begin
          $display("ok %s: chan=%0d data=%0d cycle=%0d", e.tag, out_chan, $signed(out_data), cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t post[$];
    longint s0, s1, x;

    // Stage 0 of ch3 holds 100, 187.5, 264.06; the output stage lags at 12.5, 34.375, 63.09.
    tbl.push_back(mk("pass0",     0, 0, 0, 0,  1, 0, 1000,      1000));
    tbl.push_back(mk("pass1",     0, 0, 0, 0,  1, 0, -5,        -5));
    tbl.push_back(mk("pass2",     0, 0, 0, 0,  1, 0, 134217727, 134217727));
    tbl.push_back(mk("cfg_k2",    1, 0, 1, 2,  0, 0, 0,         0));
    tbl.push_back(mk("step_seed", 0, 0, 0, 0,  1, 1, 4000,      4000));
    tbl.push_back(mk("step1",     0, 0, 0, 0,  1, 1, 0,         3750));
    tbl.push_back(mk("step2",     0, 0, 0, 0,  1, 1, 0,         3375));
    tbl.push_back(mk("arm2",      0, 1, 2, 0,  0, 0, 0,         0));
    tbl.push_back(mk("neg_seed",  0, 0, 0, 0,  1, 2, 0,         0));
    tbl.push_back(mk("cfg_k1",    1, 0, 2, 1,  0, 0, 0,         0));
    tbl.push_back(mk("neg_floor", 0, 0, 0, 0,  1, 2, -1,        -1));
    tbl.push_back(mk("cfg_k3",    1, 1, 3, 3,  0, 0, 0,         0));
    tbl.push_back(mk("il_seed3",  0, 0, 0, 0,  1, 3, 0,         0));
    tbl.push_back(mk("il_c0a",    0, 0, 0, 0,  1, 0, 100,       100));
    tbl.push_back(mk("il_c3a",    0, 0, 0, 0,  1, 3, 800,       12));
    tbl.push_back(mk("il_c0b",    0, 0, 0, 0,  1, 0, 100,       100));
    tbl.push_back(mk("il_c3b",    0, 0, 0, 0,  1, 3, 800,       34));
    tbl.push_back(mk("il_c0c",    0, 0, 0, 0,  1, 0, 100,       100));
    tbl.push_back(mk("il_c3c",    0, 0, 0, 0,  1, 3, 800,       63));
    tbl.push_back(mk("bubble",    0, 0, 0, 0,  0, 0, 0,         0));
    tbl.push_back(mk("col_old_k", 1, 0, 0, 4,  1, 0, 1600,      1600));
    tbl.push_back(mk("col_new_k", 0, 0, 0, 0,  1, 0, 0,         1593));
    tbl.push_back(mk("arm_wins",  0, 1, 0, 0,  1, 0, 0,         1582));
    tbl.push_back(mk("arm_next",  0, 0, 0, 0,  1, 0, 500,       500));

    // Reset state
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_chan",  64'(out_chan),  64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    @(posedge clock_in); #1;
    reset = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);
    idle();
    drain();

    // cfg_shift=31 must behave as k=F: min-to-max step response on ch1
    apply(mk("clamp_cfg",  1, 1, 1, 31, 0, 0, 0, 0));
    apply(mk("clamp_seed", 0, 0, 0, 0,  1, 1, -134217728, -134217728));
    s0 = -(longint'(1) <<< 51);
    s1 = s0;
    x  = longint'(134217727) <<< F;
    for (int n = 1; n <= 1500; n++) begin
      s0 = s0 + ((x - s0) >>> F);
      s1 = s1 + ((s0 - s1) >>> F);
      apply(mk($sformatf("clamp_step%0d", n), 0, 0, 0, 0, 1, 1, 134217727, int'(s1 >>> F)));
    end
    idle();
    drain();

    // Reset with two samples in flight; a sample offered during reset is ignored
    @(posedge clock_in); #1;
    in_valid = 1'b1; in_chan = 2'd0; in_data = 28'sd10;
    @(posedge clock_in); #1;
    in_chan = 2'd3; in_data = 28'sd20;
    @(posedge clock_in); #1;
    reset = 1'b1; in_chan = 2'd2; in_data = 28'sd55;
    @(posedge clock_in); #1;
    in_valid = 1'b0;
    @(negedge clock_in);
    check("rst_edge1_valid", 64'(out_valid), 64'd0);
    check("rst_edge1_data",  64'(out_data),  64'd0);
    @(negedge clock_in);
    check("rst_edge2_valid", 64'(out_valid), 64'd0);
    @(posedge clock_in); #1;
    reset = 1'b0;

    post.push_back(mk("post_c1", 0, 0, 0, 0, 1, 1, 999,  999));
    post.push_back(mk("post_c3", 0, 0, 0, 0, 1, 3, -300, -300));
    post.push_back(mk("post_c0", 0, 0, 0, 0, 1, 0, 42,   42));
    post.push_back(mk("post_c2", 0, 0, 0, 0, 1, 2, -7,   -7));
    foreach (post[i]) apply(post[i]);
    idle();
    drain();
    repeat (4) @(posedge clock_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
